// File: rtl/riscv_dcache_mem_ctrl.sv
// Line refill / write-back controller: turns one whole-line cache request into LINE_WORDS word beats.
// Define DCACHE_MEM_TIMEOUT_EN to abort a line when a beat waits TIMEOUT cycles without an ack.
module riscv_dcache_mem_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_rden,
  input  logic                     mem_wren,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [32*LINE_WORDS-1:0] mem_wdata,
  output logic                     mem_ready,
  output logic [32*LINE_WORDS-1:0] mem_rdata,
  output logic                     mem_err,
  output logic                     bus_req,
  output logic                     bus_we,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [31:0]              bus_wdata,
  input  logic [31:0]              bus_rdata,
  input  logic                     bus_ack
);

  localparam int                BEAT_W    = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(4*LINE_WORDS-1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS-1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [BEAT_W-1:0] beat;
  logic [31:0]       line_buf [LINE_WORDS];
  logic              timed_out;

  // base is line-aligned, so the beat offset never carries across the line boundary
  assign bus_addr  = base + ADDR_W'({beat, 2'b00});
  assign bus_wdata = line_buf[beat];

  for (genvar k = 0; k < LINE_WORDS; k++) begin : g_rdata
    assign mem_rdata[32*k +: 32] = line_buf[k];
  end

`ifdef DCACHE_MEM_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] wait_cnt;
  logic            err_q;

  assign timed_out = (state == XFER) && !bus_ack && (wait_cnt == TO_LAST);
  assign mem_err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != XFER || bus_ack)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 1'b1;
      if (timed_out)
        err_q <= 1'b1;
      else if (state == DONE)
        err_q <= 1'b0;
    end
  end
`else
  assign timed_out = 1'b0;
  assign mem_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      base      <= '0;
      beat      <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      mem_ready <= 1'b0;
      for (int k = 0; k < LINE_WORDS; k++)
        line_buf[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          if (mem_wren || mem_rden) begin
            base    <= mem_addr & ~OFF_MASK;
            beat    <= '0;
            bus_we  <= mem_wren;
            bus_req <= 1'b1;
            state   <= XFER;
            if (mem_wren)
              for (int k = 0; k < LINE_WORDS; k++)
                line_buf[k] <= mem_wdata[32*k +: 32];
          end
        end
        XFER: begin
          if (bus_ack) begin
            if (!bus_we)
              line_buf[beat] <= bus_rdata;
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              bus_req   <= 1'b0;
              bus_we    <= 1'b0;
              mem_ready <= 1'b1;
              state     <= DONE;
            end
          end else if (timed_out) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            mem_ready <= 1'b1;
            state     <= DONE;
          end
        end
        // the cache still holds its request level here; it must not be re-accepted
        DONE: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dcache_mem_ctrl.sv
// Bench for riscv_dcache_mem_ctrl: a transaction-level model predicts every beat, the completion cycle and the line data.
module tb_riscv_dcache_mem_ctrl;

  localparam int LW = 4;
`ifdef DCACHE_MEM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
  localparam bit TO_EN      = 1'b1;
`else
  localparam int TB_TIMEOUT = 255;
  localparam bit TO_EN      = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            mem_rden;
  logic            mem_wren;
  logic [31:0]     mem_addr;
  logic [LW*32-1:0] mem_wdata;
  logic            mem_ready;
  logic [LW*32-1:0] mem_rdata;
  logic            mem_err;
  logic            bus_req;
  logic            bus_we;
  logic [31:0]     bus_addr;
  logic [31:0]     bus_wdata;
  logic [31:0]     bus_rdata;
  logic            bus_ack;

  int vectors     = 0;
  int miscompares = 0;
  int          waits_q [LW];
  logic [31:0] rwords  [LW];

  riscv_dcache_mem_ctrl #(
    .LINE_WORDS(LW),
    .ADDR_W    (32),
    .TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_rden (mem_rden),
    .mem_wren (mem_wren),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .mem_err  (mem_err),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [LW*32-1:0] observed,
                             input logic [LW*32-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_wren = 1'b0;
      mem_rden = 1'b0;
      bus_ack  = 1'b0;
      @(negedge clk);
      checkOutput("idle_bus_req", bus_req, 0);
      checkOutput("idle_mem_ready", mem_ready, 0);
    end
  endtask

  // One whole-line request; the slave answers beat k after waits_q[k] stall cycles with rwords[k].
  // reset_after >= 0 pulls reset right after that many beats have completed.
  task automatic applyStimulus(input bit is_wr, input logic [31:0] addr,
                               input logic [LW*32-1:0] wdata, input int reset_after);
    logic [31:0]      base;
    logic [LW*32-1:0] exp_rdata;
    int  k;
    int  cur_wait;
    int  cycles;
    bit  aborted;
    bit  in_beat;
    base      = addr & ~32'(4*LW-1);
    exp_rdata = '0;
    k         = 0;
    cur_wait  = 0;
    cycles    = 0;
    aborted   = 1'b0;
    @(posedge clk); #1;
    mem_wren  = is_wr;
    mem_rden  = !is_wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    bus_ack   = 1'b0;
    @(negedge clk);
    checkOutput("accept_bus_req", bus_req, 0);
    checkOutput("accept_ready", mem_ready, 0);
    while (1) begin
      in_beat = (k < LW) && !aborted;
      @(posedge clk); #1;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      if (in_beat) begin
        if (cur_wait < waits_q[k]) cur_wait++;
        else begin
          bus_ack   = 1'b1;
          bus_rdata = rwords[k];
        end
      end
      @(negedge clk);
      cycles++;
      if (cycles > 200) begin
        checkOutput("cycle_budget", 1, 0);
        return;
      end
      if (in_beat) begin
        checkOutput("bus_req", bus_req, 1);
        checkOutput("bus_we", bus_we, is_wr);
        checkOutput("bus_addr", bus_addr, base + 32'(4*k));
        if (is_wr) checkOutput("bus_wdata", bus_wdata, wdata[32*k +: 32]);
        checkOutput("ready_early", mem_ready, 0);
        if (bus_ack) begin
          exp_rdata[32*k +: 32] = rwords[k];
          k++;
          cur_wait = 0;
          if (k == reset_after) begin
            #2 rst = 1'b0;
            #1;
            checkOutput("rst_bus_req", bus_req, 0);
            checkOutput("rst_ready", mem_ready, 0);
            checkOutput("rst_rdata", mem_rdata, 0);
            mem_wren = 1'b0;
            mem_rden = 1'b0;
            bus_ack  = 1'b0;
            @(posedge clk); #3 rst = 1'b1;
            return;
          end
        end else if (TO_EN && cur_wait == TB_TIMEOUT) begin
          aborted = 1'b1;
        end
      end else begin
        checkOutput("mem_ready", mem_ready, 1);
        checkOutput("done_bus_req", bus_req, 0);
        checkOutput("mem_err", mem_err, aborted);
        if (!is_wr && !aborted) checkOutput("mem_rdata", mem_rdata, exp_rdata);
        return;
      end
    end
  endtask

  task automatic setBeats(input int w0, input int w1, input int w2, input int w3);
    waits_q[0] = w0;
    waits_q[1] = w1;
    waits_q[2] = w2;
    waits_q[3] = w3;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [LW*32-1:0] line;
    rst       = 1'b0;
    mem_rden  = 1'b0;
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    bus_rdata = '0;
    bus_ack   = 1'b0;

    #12;
    checkOutput("rst_mem_ready", mem_ready, 0);
    checkOutput("rst_mem_err", mem_err, 0);
    checkOutput("rst_bus_req", bus_req, 0);
    checkOutput("rst_bus_we", bus_we, 0);
    checkOutput("rst_bus_addr", bus_addr, 0);
    checkOutput("rst_bus_wdata", bus_wdata, 0);
    checkOutput("rst_mem_rdata", mem_rdata, 0);
    @(posedge clk); #3 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_bus_req", bus_req, 0);
    end

    // directed refill with known data
    setBeats(0, 0, 0, 0);
    rwords[0] = 32'h11; rwords[1] = 32'h22; rwords[2] = 32'h33; rwords[3] = 32'h44;
    applyStimulus(1'b0, 32'h1000_0014, '0, -1);
    checkOutput("refill_line", mem_rdata, 128'h00000044_00000033_00000022_00000011);
    idleCycles(1);

    // write-back then allocate with no gap in between
    rwords[0] = 32'hA1; rwords[1] = 32'hB2; rwords[2] = 32'hC3; rwords[3] = 32'hD4;
    applyStimulus(1'b1, 32'h2000_0000, 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, -1);
    applyStimulus(1'b0, 32'h2000_0000, '0, -1);
    idleCycles(1);

    // two stall cycles on beat 1
    setBeats(0, 2, 0, 0);
    applyStimulus(1'b0, 32'h3000_0028, '0, -1);
    idleCycles(1);

    // reset in the middle of a refill, then restart
    setBeats(0, 0, 0, 0);
    applyStimulus(1'b0, 32'h4000_0034, '0, 2);
    applyStimulus(1'b0, 32'h4000_0034, '0, -1);
    idleCycles(1);

`ifdef DCACHE_MEM_TIMEOUT_EN
    setBeats(1000, 0, 0, 0);
    applyStimulus(1'b0, 32'h5000_0000, '0, -1);
    idleCycles(1);
    setBeats(0, 1, 0, 0);
    applyStimulus(1'b0, 32'h5000_0000, '0, -1);
    idleCycles(1);
`endif

    for (int t = 0; t < 24; t++) begin
      for (int j = 0; j < LW; j++) begin
        waits_q[j] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
        rwords[j]  = $urandom;
        line[32*j +: 32] = $urandom;
      end
      applyStimulus(1'($urandom_range(0, 1)), $urandom, line, -1);
      if ($urandom_range(0, 2) != 0) idleCycles(int'($urandom_range(1, 2)));
    end
    idleCycles(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_dcache_mem_ctrl.md
# riscv_dcache_mem_ctrl

Line-refill/write-back controller sitting directly downstream of the data-cache FSM. It accepts whole-line read (allocate) and write (write-back) requests on the cache's `mem_rden`/`mem_wren` interface. It serialises each request into `LINE_WORDS` single-word transactions on a req/ack word bus toward DRAM. When the whole line has moved, it returns a one-cycle `mem_ready` pulse.

## Interface
- `LINE_WORDS`, 4: words per cache line; power of two, 2..16.
- `ADDR_W`, 32: byte-address width.
- `TIMEOUT`, 255: max wait cycles per beat; used only with `DCACHE_MEM_TIMEOUT_EN`.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `mem_rden` in 1: line read request; level, held until `mem_ready`.
- `mem_wren` in 1: line write-back request; level, held until `mem_ready`.
- `mem_addr` in ADDR_W: byte address inside the target line.
- `mem_wdata` in 32*LINE_WORDS: line to write; word k is bits [32k+31:32k].
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32*LINE_WORDS: refilled line, same word order as `mem_wdata`.
- `mem_err` out 1: beat timed out; valid with `mem_ready`.
- `bus_req` out 1: word transaction request.
- `bus_we` out 1: 1 = write, 0 = read.
- `bus_addr` out ADDR_W: word byte-address.
- `bus_wdata` out 32: write word.
- `bus_rdata` in 32: read word; sampled on ack.
- `bus_ack` in 1: beat completes on a rising edge with `bus_req && bus_ack`.

## Operation
- States:
  - IDLE
  - XFER
  - DONE
- IDLE:
  - `mem_wren` has priority over `mem_rden` if both are high.
  - On either request: latch line base = `mem_addr` with the low log2(4*LINE_WORDS) bits cleared.
  - For a write, also latch `mem_wdata` into the line buffer.
  - Latch the direction, clear the beat counter, then go to XFER.
- XFER:
  - Drives `bus_req`=1, `bus_we`=direction, `bus_addr`=base+4*beat, `bus_wdata`=buffer word[beat].
  - On each ack:
    - Read: store `bus_rdata` into buffer word[beat].
    - Increment beat.
  - On ack of beat LINE_WORDS-1, go to DONE.
  - `bus_req` drops in the same cycle the state leaves XFER.
  - Addresses increase linearly; no wrap-around inside the line.
- DONE:
  - `mem_ready`=1 for exactly one cycle, then IDLE.
  - Requests are ignored in DONE, so the cache's held level is not re-accepted.
  - A new request in the cycle after DONE (write-back followed immediately by allocate) is accepted normally.
- `mem_rdata` holds the buffer contents.
  - Valid from the DONE cycle of a read until the next request is accepted.
  - Contents after a write are don't-care.
- Dropping the request mid-XFER is illegal. The controller finishes the line regardless.
- Reset (rst=0), asserted at any time:
  - State goes to IDLE; beat counter, buffer and all outputs go to 0.
  - `bus_req` drops asynchronously, even mid-beat.

## Timing
- All outputs are registered or decoded from state only; no combinational path from `bus_ack` to any output.
- Request high in cycle 0, zero-wait acks:
  - Beats occupy cycles 1..LINE_WORDS.
  - `mem_ready` is high in cycle LINE_WORDS+1.
- Each wait cycle on a beat adds exactly one cycle.
- Minimum spacing between accepted requests is LINE_WORDS+2 cycles.

## Configuration
- `DCACHE_MEM_TIMEOUT_EN` defined:
  - A per-beat wait counter runs while in XFER and restarts on each ack.
  - Reaching TIMEOUT cycles without an ack aborts the line: `bus_req` drops, the state goes to DONE, and `mem_err`=1 alongside `mem_ready`.
  - Buffer words not yet received keep their previous values.
- `DCACHE_MEM_TIMEOUT_EN` undefined:
  - No counter; the controller waits forever.
  - `mem_err` is tied to 0.

## Test plan
- Reset at power-up:
  - During reset: all outputs 0.
  - 3 cycles after release with no request: `bus_req` stays 0.
- Read, LINE_WORDS=4, `mem_addr`=0x1000_0014, zero-wait bus returning 0x11,0x22,0x33,0x44:
  - `bus_addr` sequence 0x1000_0010, 14, 18, 1C.
  - `mem_ready` in cycle 5.
  - `mem_rdata`=0x00000044_00000033_00000022_00000011.
- Write-back immediately followed by allocate:
  - `mem_wren` held with `mem_wdata`=0xDDDD_CCCC_BBBB_AAAA (word-wise) at 0x2000_0000, then `mem_rden` asserted the cycle after `mem_ready`.
  - Four writes of AAAA..DDDD go out, one `mem_ready`, then four reads start the next cycle.
  - There is no duplicate write line.
- Wait states:
  - Ack delayed 2 cycles on beat 1 only.
  - `mem_ready` arrives 2 cycles later than the zero-wait case.
  - `bus_addr` is stable throughout the wait.
- Reset mid-line:
  - rst=0 after beat 2 of a read.
  - `bus_req` goes to 0 immediately.
  - After release, a new request restarts at beat 0 with the base address.
- With `DCACHE_MEM_TIMEOUT_EN`, TIMEOUT=8, no ack on beat 0:
  - `mem_ready`=1 with `mem_err`=1 after 8 wait cycles.
  - The next request completes normally with `mem_err`=0.
